rt_hit_resolve: RTL and testbench
=================================

# rt_hit_resolve

Closest-hit resolver that sits directly downstream of the ray-triangle intersection unit. It consumes that unit's per-triangle candidates for one ray: hit flag plus the un-divided `det`, `un`, `vn` and `tn`. For each hit it performs the deferred fixed-point division to get `t`, `u` and `v`. It keeps the nearest hit within the ray's `tmax` and emits one resolved result per ray to the shading/traversal logic over a valid/ready handshake.

## Interface
- `W`, 32: data width; matches the intersection unit.
- `F`, 30: fraction bits; 1.0 = 2^F.
- `IDW`, 16: triangle-id width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  candidate valid.
- `in_ready`  out  1  candidate accepted when `in_valid && in_ready` at a rising edge.
- `in_hit`  in  1  upstream hit flag.
- `in_det`, `in_un`, `in_vn`, `in_tn`  in  W each  signed fixed-point numerators/denominator from the intersection unit.
- `in_tri_id`  in  IDW  triangle id.
- `in_last`  in  1  final candidate of the current ray.
- `in_tmax`  in  W  unsigned ray tmax; sampled only with the first candidate of a ray.
- `out_valid`  out  1  resolved result valid.
- `out_ready`  in  1  consumer accepts.
- `out_hit`  out  1  any accepted hit.
- `out_t`, `out_u`, `out_v`  out  W  unsigned Q(W-F).F.
- `out_tri_id`  out  IDW.

## Operation
- **States:** IDLE, DIV, CMP, EMIT. `in_ready = (state==IDLE)`. `out_valid = (state==EMIT)`.
- **First-candidate flag:**
  - Set by reset and after each EMIT handshake.
  - On accepting the first candidate of a ray: `best_t <= in_tmax`, `best_hit <= 0`, `best_u/v/id <= 0`.
- **Miss candidate** (`in_hit==0` or `in_det==0`):
  - No arithmetic.
  - `in_last=0`: stay in IDLE.
  - `in_last=1`: go to EMIT.
- **Hit candidate:**
  - Latch magnitudes |det|, |tn|, |un| and |vn|. Numerators are negated when det<0; upstream guarantees they share det's sign.
  - Latch `in_tri_id` and `in_last`. Go to DIV.
- **DIV:** three parallel restoring dividers share one counter and run W iterations.
  - Each computes q = min(floor(|n|·2^F / |det|), 2^W−1).
  - Overflow is pre-detected (|n| ≥ |det|·2^(W−F)); on overflow q is forced to all-ones.
- **CMP (1 cycle):** accept iff `qt != 0 && qt < best_t` (strict; ties keep the earlier candidate). On accept, update `best_t`, `best_u`, `best_v`, `best_id` and set `best_hit=1`. Then:
  - latched last=1: go to EMIT;
  - otherwise: go to IDLE.
- **EMIT:** outputs driven from the best registers.
  - If no hit: `out_hit=0`, `out_t=tmax`, `out_u`/`out_v`/`out_tri_id`=0.
  - Outputs hold stable while `out_ready=0`.
  - On handshake: go to IDLE and set the first-candidate flag.
- **Reset** (including mid-DIV/EMIT): state IDLE, in-flight candidate and partial ray discarded.
  - `out_valid=0`, `out_hit=0`, `out_t/u/v=0`, `out_tri_id=0`.
  - All best registers 0; first-candidate flag set.

## Timing
- **Hit accepted at edge E:**
  - DIV occupies edges E+1..E+W; CMP occurs at edge E+W+1.
  - `in_ready` is low from after E until edge E+W+1.
  - Next acceptance is possible at E+W+2, giving W+2 cycles per hit.
- **Hit with last accepted at E:** `out_valid` rises after edge E+W+1.
- **Miss accepted at E:**
  - `in_ready` stays high, so one miss per cycle.
  - If last: `out_valid` rises after E.
- **EMIT handshake at edge H:** `in_ready` is high after H, so a new ray can be accepted at H+1.
- No combinational path from `in_*` to `out_*`. `in_ready` is purely state-decoded.

## Test plan
- **Single hit:** det=0x40000000, tn=0x80000000·½ (0x40000000), un=vn=0x10000000, last=1, tmax=0xFFFFFFFF.
  - Expect `out_hit=1`, `t=0x40000000`, `u=v=0x10000000`.
  - `out_valid` rises 33 edges after acceptance.
- **Negative det:** det=0xC0000000, tn=0xE0000000, un=0xF0000000, vn=0xF0000000.
  - Expect `t=0x20000000`, `u=v=0x10000000`.
- **Three hits:** t = 0.75, 0.25, 0.25 (ids 5, 7, 9), last on the third.
  - Expect `t=0x10000000`, `out_tri_id=7` (tie keeps the earlier id).
- **tmax and saturation:** tmax=0x20000000; candidates are a t=0.75 hit, a miss, and a hit with det=1, tn=0x40000000 that saturates to 0xFFFFFFFF; last on the third.
  - Expect `out_hit=0`, `out_t=0x20000000`, `u/v/id=0`.
- **Back-to-back misses:** four consecutive misses, last on the fourth.
  - Expect `in_ready` held high, `out_valid` one edge after the fourth.
  - Hold `out_ready=0` for 5 cycles: outputs stable and `in_ready=0` throughout.
- **Reset mid-DIV:** assert `rst` 10 cycles after a hit is accepted.
  - Expect all outputs 0 and `in_ready=1` the next cycle.
  - A following single-hit ray resolves correctly with its own tmax.

Source files
------------

// File: rtl/rt_hit_resolve.sv
// Closest-hit resolver: divides deferred intersection numerators by det and
// keeps the nearest accepted hit per ray, emitting one result per ray.
module rt_hit_resolve #(
  parameter int W   = 32,
  parameter int F   = 30,
  parameter int IDW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_hit,
  input  logic [W-1:0]   in_det,
  input  logic [W-1:0]   in_un,
  input  logic [W-1:0]   in_vn,
  input  logic [W-1:0]   in_tn,
  input  logic [IDW-1:0] in_tri_id,
  input  logic           in_last,
  input  logic [W-1:0]   in_tmax,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_hit,
  output logic [W-1:0]   out_t,
  output logic [W-1:0]   out_u,
  output logic [W-1:0]   out_v,
  output logic [IDW-1:0] out_tri_id,
  output logic [1:0]     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and payload is held until taken.

  localparam int SH = W - F;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CMP, S_EMIT} state_t;

  state_t r_state, w_next;

  logic [CW-1:0]  r_cnt;
  logic           r_first;
  logic           r_last;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_den;
  logic [W-1:0]   r_rem [3];
  logic [W-1:0]   r_lo  [3];
  logic [W-1:0]   r_q   [3];
  logic           r_ovf [3];

  logic           r_best_hit;
  logic [W-1:0]   r_best_t;
  logic [W-1:0]   r_best_u;
  logic [W-1:0]   r_best_v;
  logic [IDW-1:0] r_best_id;

  logic           w_accept;
  logic           w_miss;
  logic           w_neg;
  logic [W-1:0]   w_dmag;
  logic [W-1:0]   w_num     [3];
  logic           w_ovf_in  [3];
  logic [W:0]     w_sh      [3];
  logic           w_ge      [3];
  logic [W-1:0]   w_sub     [3];
  logic [W-1:0]   w_rem_nx  [3];
  logic [W-1:0]   w_qs      [3];
  logic           w_take;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_miss   = !in_hit || (in_det == '0);
  assign w_neg    = in_det[W-1];
  assign w_dmag   = w_neg ? -in_det : in_det;

  // Numerators share det's sign upstream, so negating with det yields magnitudes.
  always_comb begin
    w_num[0] = w_neg ? -in_tn : in_tn;
    w_num[1] = w_neg ? -in_un : in_un;
    w_num[2] = w_neg ? -in_vn : in_vn;
    for (int k = 0; k < 3; k++) begin
      w_ovf_in[k] = {{SH{1'b0}}, w_num[k]} >= {w_dmag, {SH{1'b0}}};
    end
  end

  // One restoring step per divider; remainder always stays below the divisor.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_sh[k]     = {r_rem[k], r_lo[k][W-1]};
      w_ge[k]     = w_sh[k] >= {1'b0, r_den};
      w_sub[k]    = w_sh[k][W-1:0] - r_den;
      w_rem_nx[k] = w_ge[k] ? w_sub[k] : w_sh[k][W-1:0];
      w_qs[k]     = r_ovf[k] ? '1 : r_q[k];
    end
  end

  assign w_take = (r_state == S_CMP) && (w_qs[0] != '0) && (w_qs[0] < r_best_t);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_miss) w_next = in_last ? S_EMIT : S_IDLE;
          else        w_next = S_DIV;
        end
      end
      S_DIV:  if (r_cnt == CW'(W - 1)) w_next = S_CMP;
      S_CMP:  w_next = r_last ? S_EMIT : S_IDLE;
      S_EMIT: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_first    <= 1'b1;
      r_last     <= 1'b0;
      r_id       <= '0;
      r_den      <= '0;
      r_best_hit <= 1'b0;
      r_best_t   <= '0;
      r_best_u   <= '0;
      r_best_v   <= '0;
      r_best_id  <= '0;
      for (int k = 0; k < 3; k++) begin
        r_rem[k] <= '0;
        r_lo[k]  <= '0;
        r_q[k]   <= '0;
        r_ovf[k] <= 1'b0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (r_first) begin
              r_best_t   <= in_tmax;
              r_best_hit <= 1'b0;
              r_best_u   <= '0;
              r_best_v   <= '0;
              r_best_id  <= '0;
              r_first    <= 1'b0;
            end
            if (!w_miss) begin
              r_den  <= w_dmag;
              r_id   <= in_tri_id;
              r_last <= in_last;
              r_cnt  <= '0;
              // Dividend is |n|*2^F: high part seeds the remainder, low part shifts in.
              for (int k = 0; k < 3; k++) begin
                r_rem[k] <= {{SH{1'b0}}, w_num[k][W-1:SH]};
                r_lo[k]  <= {w_num[k][SH-1:0], {F{1'b0}}};
                r_q[k]   <= '0;
                r_ovf[k] <= w_ovf_in[k];
              end
            end
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          for (int k = 0; k < 3; k++) begin
            r_rem[k] <= w_rem_nx[k];
            r_lo[k]  <= {r_lo[k][W-2:0], 1'b0};
            r_q[k]   <= {r_q[k][W-2:0], w_ge[k]};
          end
        end
        S_CMP: begin
          if (w_take) begin
            r_best_hit <= 1'b1;
            r_best_t   <= w_qs[0];
            r_best_u   <= w_qs[1];
            r_best_v   <= w_qs[2];
            r_best_id  <= r_id;
          end
        end
        S_EMIT: begin
          if (out_ready) r_first <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_EMIT);
  assign out_hit    = r_best_hit;
  assign out_t      = r_best_t;
  assign out_u      = r_best_u;
  assign out_v      = r_best_v;
  assign out_tri_id = r_best_id;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rt_hit_resolve.sv
// Self-checking bench for rt_hit_resolve: per-ray reference model feeds an
// expected queue that is checked whenever a result handshake occurs.
module tb_rt_hit_resolve;

  localparam int W   = 32;
  localparam int F   = 30;
  localparam int IDW = 16;
  localparam int EW  = 1 + 3 * W + IDW;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_hit;
  logic [W-1:0]   in_det, in_un, in_vn, in_tn;
  logic [IDW-1:0] in_tri_id;
  logic           in_last;
  logic [W-1:0]   in_tmax;
  logic           out_valid;
  logic           out_ready;
  logic           out_hit;
  logic [W-1:0]   out_t, out_u, out_v;
  logic [IDW-1:0] out_tri_id;
  logic [1:0]     dbg_state;

  rt_hit_resolve #(.W(W), .F(F), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit),
    .in_det(in_det), .in_un(in_un), .in_vn(in_vn), .in_tn(in_tn),
    .in_tri_id(in_tri_id), .in_last(in_last), .in_tmax(in_tmax),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_t(out_t), .out_u(out_u), .out_v(out_v), .out_tri_id(out_tri_id),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int acc_cyc = 0;

  logic [EW-1:0] exp_q[$];

  // Reference ray state
  logic           m_first = 1'b1;
  logic           m_hit;
  logic [W-1:0]   m_t, m_u, m_v;
  logic [IDW-1:0] m_id;

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [2*W-1:0] num;
    logic [2*W-1:0] q;
    num = {{W{1'b0}}, n} << F;
    q   = num / {{W{1'b0}}, d};
    if (q[2*W-1:W] != '0) return '1;
    return q[W-1:0];
  endfunction

  // Scoreboard: compare every result handshake against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [EW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result with empty queue t=%h id=%0d", out_t, out_tri_id);
      end else begin
        e = exp_q.pop_front();
        checks += 4;
        if (out_hit !== e[EW-1]) begin
          errors++; $display("FAIL sb_hit: got %b want %b", out_hit, e[EW-1]);
        end
        if (out_t !== e[EW-2 -: W]) begin
          errors++; $display("FAIL sb_t: got %h want %h", out_t, e[EW-2 -: W]);
        end
        if (out_u !== e[EW-2-W -: W]) begin
          errors++; $display("FAIL sb_u: got %h want %h", out_u, e[EW-2-W -: W]);
        end
        if ({out_v, out_tri_id} !== e[W+IDW-1:0]) begin
          errors++; $display("FAIL sb_v_id: got %h/%0d want %h/%0d", out_v, out_tri_id,
                             e[W+IDW-1:IDW], e[IDW-1:0]);
        end
      end
    end
  end

  // Driver: update the reference model, then present one candidate until taken
  task automatic send_cand(input logic hit, input logic [W-1:0] det, input logic [W-1:0] un,
                           input logic [W-1:0] vn, input logic [W-1:0] tn,
                           input logic [IDW-1:0] id, input logic last, input logic [W-1:0] tmax);
    int n;
    logic neg;
    logic [W-1:0] dm, tq;
    if (m_first) begin
      m_t = tmax; m_hit = 1'b0; m_u = '0; m_v = '0; m_id = '0; m_first = 1'b0;
    end
    if (hit && det != '0) begin
      neg = det[W-1];
      dm  = neg ? -det : det;
      tq  = ref_div(neg ? -tn : tn, dm);
      if (tq != '0 && tq < m_t) begin
        m_hit = 1'b1; m_t = tq; m_id = id;
        m_u = ref_div(neg ? -un : un, dm);
        m_v = ref_div(neg ? -vn : vn, dm);
      end
    end
    if (last) begin
      exp_q.push_back({m_hit, m_t, m_u, m_v, m_id});
      m_first = 1'b1;
    end
    in_valid = 1'b1; in_hit = hit; in_det = det; in_un = un; in_vn = vn; in_tn = tn;
    in_tri_id = id; in_last = last; in_tmax = tmax;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 200) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL out_timeout: out_valid=%b want 1", out_valid);
    end else begin
      lat = cyc - acc_cyc;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if ({out_hit, out_t, out_u, out_v, out_tri_id} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b/%h/%h/%h/%0d want zeros", out_hit, out_t, out_u, out_v, out_tri_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_hit();
    int lat;
    send_cand(1'b1, 32'h40000000, 32'h10000000, 32'h10000000, 32'h40000000, 16'd3, 1'b1, 32'hFFFFFFFF);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL single_busy: in_ready=%b want 0", in_ready); end
    wait_out(lat);
    checks++;
    if (lat != W + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_negative_det();
    int lat;
    send_cand(1'b1, 32'hC0000000, 32'hF0000000, 32'hF0000000, 32'hE0000000, 16'd4, 1'b1, 32'hFFFFFFFF);
    wait_out(lat);
  endtask

  task automatic test_three_hits();
    int lat;
    send_cand(1'b1, 32'h40000000, 32'h01000000, 32'h04000000, 32'h30000000, 16'd5, 1'b0, 32'hFFFFFFFF);
    send_cand(1'b1, 32'h40000000, 32'h02000000, 32'h04000000, 32'h10000000, 16'd7, 1'b0, 32'h0);
    send_cand(1'b1, 32'h40000000, 32'h03000000, 32'h04000000, 32'h10000000, 16'd9, 1'b1, 32'h0);
    wait_out(lat);
  endtask

  task automatic test_tmax_sat();
    int lat;
    send_cand(1'b1, 32'h40000000, 32'h01000000, 32'h01000000, 32'h30000000, 16'd1, 1'b0, 32'h20000000);
    send_cand(1'b0, 32'h40000000, 32'h0, 32'h0, 32'h08000000, 16'd2, 1'b0, 32'h0);
    send_cand(1'b1, 32'h00000001, 32'h0, 32'h0, 32'h40000000, 16'd3, 1'b1, 32'h0);
    wait_out(lat);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      send_cand(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 16'(i), i == 3, 32'h12345678);
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_hold%0d: valid=%b ready=%b want 1/0", i, out_valid, in_ready);
      end
      if (out_hit !== 1'b0 || out_t !== 32'h12345678 || out_tri_id !== '0) begin
        errors++; $display("FAIL b2b_stable%0d: hit=%b t=%h id=%0d want 0/12345678/0", i, out_hit, out_t, out_tri_id);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_after: ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    send_cand(1'b1, 32'h40000000, 32'h10000000, 32'h10000000, 32'h20000000, 16'd11, 1'b1, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    void'(exp_q.pop_back());
    m_first = 1'b1;
    checks += 2;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstdiv_hs: ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    if ({out_hit, out_t, out_u, out_v, out_tri_id} !== '0) begin
      errors++; $display("FAIL rstdiv_outputs: got %b/%h/%h/%h/%0d want zeros", out_hit, out_t, out_u, out_v, out_tri_id);
    end
    send_cand(1'b1, 32'h40000000, 32'h08000000, 32'h04000000, 32'h20000000, 16'd12, 1'b1, 32'h30000000);
    wait_out(lat);
  endtask

  task automatic test_random();
    int lat, ncand;
    logic neg, hit;
    logic [W-1:0] d, t, u, v, tmax;
    for (int r = 0; r < 6; r++) begin
      ncand = $urandom_range(1, 4);
      tmax  = $urandom_range(32'h08000000, 32'hFFFFFFFF);
      for (int c = 0; c < ncand; c++) begin
        neg = 1'($urandom_range(0, 1));
        hit = ($urandom_range(0, 3) != 0);
        d = $urandom_range(32'h00100000, 32'h7FFFFFFF);
        t = $urandom_range(0, 32'h3FFFFFFF);
        u = $urandom_range(0, 32'h0FFFFFFF);
        v = $urandom_range(0, 32'h0FFFFFFF);
        if (neg) begin d = -d; t = -t; u = -u; v = -v; end
        send_cand(hit, d, u, v, t, 16'($urandom_range(0, 65535)), c == ncand - 1, tmax);
      end
      wait_out(lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_hit = 1'b0; in_det = '0; in_un = '0; in_vn = '0;
    in_tn = '0; in_tri_id = '0; in_last = 1'b0; in_tmax = '0; out_ready = 1'b1;
    test_reset();
    test_single_hit();
    test_negative_det();
    test_three_hits();
    test_tmax_sat();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d results outstanding want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
